struct_field_assembler: RTL and testbench

//  Upstream producer for the 13-bit packed record {x, y, z}.
//  - x: 2 elements x 3 bits, descending, so x[1] is the MSB element.
//  - y: 3 elements x 2 bits, ascending, so y[0] is the MSB element.
//  - z: 1 bit.

---
 rtl/struct_asm_pkg.sv | 52 +++++
 rtl/struct_asm_field.sv | 70 +++++++
 rtl/struct_field_assembler.sv | 217 +++++++++++++++++++++
 tb/tb_struct_field_assembler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/struct_asm_pkg.sv
// ============================================================================
// Module      : struct_asm_pkg
// Description : Shared types and constants for the struct_field_assembler
//               slice. Holds the command/field encodings, the record geometry
//               and the helper that places x, y and z into the packed record.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package struct_asm_pkg;

    // Record geometry
    localparam int X_N    = 2;
    localparam int X_W    = 3;
    localparam int Y_N    = 3;
    localparam int Y_W    = 2;
    localparam int PACK_W = X_N * X_W + Y_N * Y_W + 1;
    localparam int DATA_W = (X_W > Y_W) ? X_W : Y_W;

    typedef enum logic [1:0] {
        OP_WR_ELEM = 2'd0,
        OP_WR_BIT  = 2'd1,
        OP_FILL    = 2'd2,
        OP_COMMIT  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        FLD_X   = 2'd0,
        FLD_Y   = 2'd1,
        FLD_Z   = 2'd2,
        FLD_ILL = 2'd3
    } field_e;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_SEND    = 1'b1
    } state_e;

    // The packed record is {x view, y view, z}: x occupies the MSBs and z
    // is bit 0. The views already carry their own element ordering.
    function automatic logic [PACK_W-1:0] pack_record(
        input logic [X_N*X_W-1:0] x_view,
        input logic [Y_N*Y_W-1:0] y_view,
        input logic               z_bit
    );
        return {x_view, y_view, z_bit};
    endfunction

endpackage

`default_nettype wire

// File: rtl/struct_asm_field.sv
// ============================================================================
// Module      : struct_asm_field
// Description : One element-array register of N elements x W bits with three
//               write ports (whole element, single bit, fill) and a packed
//               view. ASCEND=0 places element N-1 in the MSBs; ASCEND=1
//               places element 0 in the MSBs.
// Ports       : clk, rst_n          - clock, async active-low reset
//               elem_we, bit_we,
//               fill_we             - write strobes (already qualified)
//               idx, bit_sel        - element / bit selection (in range)
//               data                - write data, LSB-aligned
//               view                - packed view of all elements
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module struct_asm_field #(
    parameter int N      = 2,
    parameter int W      = 3,
    parameter bit ASCEND = 1'b0,
    parameter int IDX_W  = 2,
    parameter int BIT_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             elem_we,
    input  logic             bit_we,
    input  logic             fill_we,
    input  logic [IDX_W-1:0] idx,
    input  logic [BIT_W-1:0] bit_sel,
    input  logic [W-1:0]     data,
    output logic [N*W-1:0]   view
);

    // Single-bit writes are done as a masked merge so the bit index never
    // needs to be narrower than the port.
    logic [W-1:0] bit_mask;
    logic [W-1:0] fill_val;

    assign bit_mask = W'(1) << bit_sel;
    assign fill_val = {W{data[0]}};

    for (genvar i = 0; i < N; i++) begin : g_elem
        logic [W-1:0] elem_q;
        logic         sel;

        assign sel = (idx == IDX_W'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                elem_q <= '0;
            end else if (fill_we) begin
                elem_q <= fill_val;
            end else if (elem_we && sel) begin
                elem_q <= data;
            end else if (bit_we && sel) begin
                elem_q <= (elem_q & ~bit_mask) | (fill_val & bit_mask);
            end
        end

        if (ASCEND) begin : g_asc
            assign view[(N-1-i)*W +: W] = elem_q;
        end else begin : g_desc
            assign view[i*W +: W] = elem_q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/struct_field_assembler.sv
// ============================================================================
// Module      : struct_field_assembler
// Description : Builds the packed record {x, y, z} from a valid/ready command
//               stream (element, bit and fill writes) and, on COMMIT, hands a
//               snapshot to the downstream consumer over valid/ready.
//               Optional macro STRUCT_ASM_PARITY_EN adds out_parity, the XOR
//               of the snapshot, registered together with it.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid/in_ready    - command handshake
//               in_op, in_field,
//               in_idx, in_bit,
//               in_data              - command payload
//               out_valid/out_ready  - snapshot handshake
//               out_data             - snapshot {x, y, z}
//               out_x, out_y, out_z  - live record views
//               err                  - one-cycle pulse on a rejected command
//               out_parity           - ^out_data (STRUCT_ASM_PARITY_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module struct_field_assembler
    import struct_asm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [1:0]         in_field,
    input  logic [1:0]         in_idx,
    input  logic [1:0]         in_bit,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PACK_W-1:0]  out_data,
    output logic [X_N*X_W-1:0] out_x,
    output logic [Y_N*Y_W-1:0] out_y,
    output logic               out_z,
    output logic               err
`ifdef STRUCT_ASM_PARITY_EN
    ,
    output logic               out_parity
`endif
);

    op_e    op;
    field_e fld;
    state_e state;
    state_e state_next;

    logic accept;
    logic snap_load;
    logic legal;
    logic wr;
    logic x_idx_ok, x_bit_ok, y_idx_ok, y_bit_ok;
    logic z_zero_idx, z_zero_bit;

    assign op     = op_e'(in_op);
    assign fld    = field_e'(in_field);
    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        snap_load  = 1'b0;
        case (state)
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (op == OP_COMMIT)) begin
                    snap_load  = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_COLLECT;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Command legality: each op checks only the selectors it uses; COMMIT
    // is always legal and handled by the FSM above.
    // ------------------------------------------------------------------
    assign x_idx_ok   = 32'(in_idx) < X_N;
    assign x_bit_ok   = 32'(in_bit) < X_W;
    assign y_idx_ok   = 32'(in_idx) < Y_N;
    assign y_bit_ok   = 32'(in_bit) < Y_W;
    assign z_zero_idx = (in_idx == 2'd0);
    assign z_zero_bit = (in_bit == 2'd0);

    always_comb begin
        legal = 1'b0;
        case (fld)
            FLD_X: begin
                case (op)
                    OP_WR_ELEM: legal = x_idx_ok;
                    OP_WR_BIT:  legal = x_idx_ok && x_bit_ok;
                    default:    legal = 1'b1;
                endcase
            end
            FLD_Y: begin
                case (op)
                    OP_WR_ELEM: legal = y_idx_ok;
                    OP_WR_BIT:  legal = y_idx_ok && y_bit_ok;
                    default:    legal = 1'b1;
                endcase
            end
            FLD_Z: begin
                case (op)
                    OP_WR_ELEM: legal = z_zero_idx;
                    OP_WR_BIT:  legal = z_zero_idx && z_zero_bit;
                    default:    legal = 1'b1;
                endcase
            end
            default: legal = (op == OP_COMMIT);
        endcase
    end

    assign wr = accept && legal && (op != OP_COMMIT);

    // ------------------------------------------------------------------
    // Record storage
    // ------------------------------------------------------------------
    struct_asm_field #(
        .N      (X_N),
        .W      (X_W),
        .ASCEND (1'b0),
        .IDX_W  (2),
        .BIT_W  (2)
    ) u_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .elem_we (wr && (fld == FLD_X) && (op == OP_WR_ELEM)),
        .bit_we  (wr && (fld == FLD_X) && (op == OP_WR_BIT)),
        .fill_we (wr && (fld == FLD_X) && (op == OP_FILL)),
        .idx     (in_idx),
        .bit_sel (in_bit),
        .data    (in_data[X_W-1:0]),
        .view    (out_x)
    );

    struct_asm_field #(
        .N      (Y_N),
        .W      (Y_W),
        .ASCEND (1'b1),
        .IDX_W  (2),
        .BIT_W  (2)
    ) u_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .elem_we (wr && (fld == FLD_Y) && (op == OP_WR_ELEM)),
        .bit_we  (wr && (fld == FLD_Y) && (op == OP_WR_BIT)),
        .fill_we (wr && (fld == FLD_Y) && (op == OP_FILL)),
        .idx     (in_idx),
        .bit_sel (in_bit),
        .data    (in_data[Y_W-1:0]),
        .view    (out_y)
    );

    // z is a single bit, so every legal write form reduces to z <= data[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_z <= 1'b0;
        end else if (wr && (fld == FLD_Z)) begin
            out_z <= in_data[0];
        end
    end

    // ------------------------------------------------------------------
    // Snapshot and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (snap_load) begin
            out_data <= pack_record(out_x, out_y, out_z);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= accept && (op != OP_COMMIT) && !legal;
        end
    end

`ifdef STRUCT_ASM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (snap_load) begin
            out_parity <= ^pack_record(out_x, out_y, out_z);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_struct_field_assembler.sv
// ============================================================================
// Module      : tb_struct_field_assembler
// Description : Self-checking bench for struct_field_assembler. Directed
//               scenarios followed by randomized commands, all checked against
//               an array-based model of the record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_struct_field_assembler;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [1:0]  in_field;
    logic [1:0]  in_idx;
    logic [1:0]  in_bit;
    logic [2:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic [5:0]  out_x;
    logic [5:0]  out_y;
    logic        out_z;
    logic        err;
`ifdef STRUCT_ASM_PARITY_EN
    logic        out_parity;
`endif

    struct_field_assembler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_field  (in_field),
        .in_idx    (in_idx),
        .in_bit    (in_bit),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .err       (err)
`ifdef STRUCT_ASM_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: record as plain integer arrays.
    int mx [2];
    int my [3];
    int mz;
    int msnap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_x();
        return mx[1] * 8 + mx[0];
    endfunction

    function automatic int model_y();
        return my[0] * 16 + my[1] * 4 + my[2];
    endfunction

    function automatic int model_pack();
        return (model_x() * 64 + model_y()) * 2 + mz;
    endfunction

    function automatic void model_clear();
        mx[0] = 0; mx[1] = 0;
        my[0] = 0; my[1] = 0; my[2] = 0;
        mz = 0; msnap = 0;
    endfunction

    function automatic int get_el(int f, int i);
        return (f == 0) ? mx[i] : my[i];
    endfunction

    function automatic void set_el(int f, int i, int v);
        if (f == 0) mx[i] = v; else my[i] = v;
    endfunction

    // Applies one non-COMMIT command; returns 1 when it must be rejected.
    function automatic int model_apply(int op, int f, int idx, int b, int data);
        int n, w, v, d0;
        d0 = data % 2;
        if (f == 3) return 1;
        if (f == 2) begin
            if (op == 0 && idx != 0) return 1;
            if (op == 1 && (idx != 0 || b != 0)) return 1;
            mz = d0;
            return 0;
        end
        n = (f == 0) ? 2 : 3;
        w = (f == 0) ? 3 : 2;
        case (op)
            0: begin
                if (idx >= n) return 1;
                set_el(f, idx, data % (1 << w));
            end
            1: begin
                if (idx >= n || b >= w) return 1;
                v = get_el(f, idx);
                v = (v & ~(1 << b)) | (d0 << b);
                set_el(f, idx, v);
            end
            default: begin
                for (int i = 0; i < n; i++) set_el(f, i, d0 ? (1 << w) - 1 : 0);
            end
        endcase
        return 0;
    endfunction

    task automatic cmd(input int op, input int f, input int idx, input int b, input int data);
        int e;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'(op);
        in_field = 2'(f);
        in_idx   = 2'(idx);
        in_bit   = 2'(b);
        in_data  = 3'(data);
        chk("in_ready_collect", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (op == 3) begin
            msnap = model_pack();
            chk("commit_out_valid", {31'b0, out_valid}, 1);
            chk("commit_in_ready", {31'b0, in_ready}, 0);
            chk("commit_out_data", {19'b0, out_data}, msnap);
            chk("commit_err", {31'b0, err}, 0);
`ifdef STRUCT_ASM_PARITY_EN
            chk("commit_parity", {31'b0, out_parity}, {31'b0, ^msnap});
`endif
        end else begin
            e = model_apply(op, f, idx, b, data);
            chk("err", {31'b0, err}, e);
            chk("out_x", {26'b0, out_x}, model_x());
            chk("out_y", {26'b0, out_y}, model_y());
            chk("out_z", {31'b0, out_z}, mz);
            chk("no_out_valid", {31'b0, out_valid}, 0);
        end
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        chk("err_one_cycle", {31'b0, err}, 0);
        chk("idle_out_x", {26'b0, out_x}, model_x());
        chk("idle_out_y", {26'b0, out_y}, model_y());
        chk("idle_out_z", {31'b0, out_z}, mz);
    endtask

    // Holds the snapshot for `hold` cycles with junk commands offered, then
    // lets one transfer happen.
    task automatic drain(input int hold);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_field = 2'($urandom_range(0, 2));
            in_idx   = 2'd0;
            in_bit   = 2'd0;
            in_data  = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'b0, out_valid}, 1);
            chk("hold_in_ready", {31'b0, in_ready}, 0);
            chk("hold_out_data", {19'b0, out_data}, msnap);
            chk("hold_out_x", {26'b0, out_x}, model_x());
            chk("hold_out_y", {26'b0, out_y}, model_y());
            chk("hold_err", {31'b0, err}, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("xfer_out_valid", {31'b0, out_valid}, 1);
        chk("xfer_out_data", {19'b0, out_data}, msnap);
`ifdef STRUCT_ASM_PARITY_EN
        chk("xfer_parity", {31'b0, out_parity}, {31'b0, ^msnap});
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_xfer_out_valid", {31'b0, out_valid}, 0);
        chk("after_xfer_in_ready", {31'b0, in_ready}, 1);
    endtask

    initial begin
        int r, op, f, idx, b, d;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_field  = 2'd0;
        in_idx    = 2'd0;
        in_bit    = 2'd0;
        in_data   = 3'd0;
        out_ready = 1'b0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {19'b0, out_data}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_record", {19'b0, out_x, out_y, out_z}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: empty commit
        cmd(3, 0, 0, 0, 0);
        chk("t1_data", {19'b0, out_data}, 0);
        drain(0);

        // 2: Y fill then clear one bit
        cmd(2, 1, 0, 0, 1);
        cmd(1, 1, 1, 1, 0);
        chk("t2_out_y", {26'b0, out_y}, 32'b110111);
        cmd(3, 0, 0, 0, 0);
        chk("t2_out_data", {19'b0, out_data}, 32'b0000001101110);
        drain(0);

        // 3: X fill, bit clear, element write
        cmd(2, 0, 0, 0, 1);
        cmd(1, 0, 1, 1, 0);
        cmd(0, 0, 0, 0, 3'b010);
        chk("t3_out_x", {26'b0, out_x}, 32'b101010);
        cmd(3, 0, 0, 0, 0);
        chk("t3_out_data_hi", {26'b0, out_data[12:7]}, 32'b101010);

        // 4: back-pressure for 5 cycles
        drain(5);

        // 5: rejected commands
        cmd(0, 0, 2, 0, 5);
        idle_check();
        cmd(1, 1, 0, 2, 1);
        idle_check();
        cmd(0, 2, 1, 0, 1);
        idle_check();
        cmd(2, 3, 0, 0, 1);
        idle_check();
        chk("t5_record", {26'b0, out_x}, 32'b101010);

        // Randomized commands
        for (int n = 0; n < 200; n++) begin
            r   = $urandom_range(0, 9);
            op  = (r < 3) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : 3;
            f   = $urandom_range(0, 3);
            idx = (op < 2) ? $urandom_range(0, 3) : 0;
            b   = (op == 1) ? $urandom_range(0, 3) : 0;
            d   = $urandom_range(0, 7);
            cmd(op, f, idx, b, d);
            if (op == 3) drain($urandom_range(0, 3));
        end

        // 6: reset during SEND
        cmd(2, 0, 0, 0, 1);
        cmd(3, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("t6_out_valid", {31'b0, out_valid}, 0);
        chk("t6_in_ready", {31'b0, in_ready}, 1);
        chk("t6_out_data", {19'b0, out_data}, 0);
        chk("t6_record", {19'b0, out_x, out_y, out_z}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd(3, 0, 0, 0, 0);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
